// File: rtl/seq_detector_param.sv
// Serial pattern detector with a runtime-programmable pattern, length and overlap mode.
// It produces a registered match pulse and a saturating match counter with a sticky saturation flag.
module seq_detector_param #(
    parameter int MAXLEN = 8,
    parameter int CW     = 8,
    parameter int LW     = $clog2(MAXLEN + 1)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              w,
    input  logic              en,
    input  logic              clr,
    input  logic [MAXLEN-1:0] pat,
    input  logic [LW-1:0]     len,
    input  logic              overlap,
    output logic              z,
    output logic [CW-1:0]     match_cnt,
    output logic              cnt_sat
);

    localparam logic [LW:0]   MAXLEN_W = (LW + 1)'(MAXLEN);
    localparam logic [CW-1:0] CNT_MAX  = '1;

    logic [MAXLEN-1:0] hist_reg, hist_next;
    logic [LW-1:0]     fill_reg, fill_next;
    logic              z_reg, z_next;
    logic [CW-1:0]     cnt_reg, cnt_next;
    logic              sat_reg, sat_next;

    logic [MAXLEN-1:0] nh;
    logic [MAXLEN-1:0] len_mask;
    logic [LW:0]       eff_len;
    logic [LW:0]       fill_plus;
    logic [LW-1:0]     fill_inc;
    logic              hit;

    assign nh        = {hist_reg[MAXLEN-2:0], w};
    assign eff_len   = ({1'b0, len} > MAXLEN_W) ? MAXLEN_W : {1'b0, len};
    assign fill_plus = {1'b0, fill_reg} + 1'b1;
    assign fill_inc  = (fill_plus > MAXLEN_W) ? MAXLEN_W[LW-1:0] : fill_plus[LW-1:0];

    // Bit gi of the mask selects history/pattern bits inside the active length.
    generate
        for (genvar gi = 0; gi < MAXLEN; gi++) begin : g_mask
            assign len_mask[gi] = ((LW + 1)'(gi) < eff_len);
        end
    endgenerate

    assign hit = (eff_len != '0) && (fill_plus >= eff_len) &&
                 (((nh ^ pat) & len_mask) == '0);

    always_comb begin
        hist_next = hist_reg;
        fill_next = fill_reg;
        z_next    = 1'b0;
        cnt_next  = cnt_reg;
        sat_next  = sat_reg;
        if (clr) begin
            hist_next = '0;
            fill_next = '0;
            cnt_next  = '0;
            sat_next  = 1'b0;
        end else if (en) begin
            hist_next = nh;
            z_next    = hit;
            // Non-overlapping mode discards the bits consumed by a match.
            fill_next = (!overlap && hit) ? '0 : fill_inc;
            if (hit) begin
                if (cnt_reg != CNT_MAX)
                    cnt_next = cnt_reg + 1'b1;
                if (cnt_reg >= CNT_MAX - 1'b1)
                    sat_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hist_reg <= '0;
            fill_reg <= '0;
            z_reg    <= 1'b0;
            cnt_reg  <= '0;
            sat_reg  <= 1'b0;
        end else begin
            hist_reg <= hist_next;
            fill_reg <= fill_next;
            z_reg    <= z_next;
            cnt_reg  <= cnt_next;
            sat_reg  <= sat_next;
        end
    end

    assign z         = z_reg;
    assign match_cnt = cnt_reg;
    assign cnt_sat   = sat_reg;

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed testbench for seq_detector_param: one wide-counter instance and one 2-bit-counter instance
// share the same stimulus.
module tb_seq_detector_param;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       w = 1'b0;
    logic       en = 1'b0;
    logic       clr = 1'b0;
    logic [7:0] pat = 8'h00;
    logic [3:0] len = 4'd0;
    logic       overlap = 1'b1;
    logic       z, z2, cnt_sat, cnt_sat2;
    logic [7:0] match_cnt;
    logic [1:0] match_cnt2;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    seq_detector_param #(.MAXLEN(8), .CW(8)) dut (
        .clk(clk), .resetn(resetn), .w(w), .en(en), .clr(clr), .pat(pat), .len(len),
        .overlap(overlap), .z(z), .match_cnt(match_cnt), .cnt_sat(cnt_sat)
    );

    seq_detector_param #(.MAXLEN(8), .CW(2)) dut2 (
        .clk(clk), .resetn(resetn), .w(w), .en(en), .clr(clr), .pat(pat), .len(len),
        .overlap(overlap), .z(z2), .match_cnt(match_cnt2), .cnt_sat(cnt_sat2)
    );

    task automatic send(input logic b);
        @(negedge clk);
        w = b; en = 1'b1; clr = 1'b0;
        @(posedge clk);
        #1;
        $display("bit w=%0b z=%0b cnt=%0d z2=%0b cnt2=%0d sat2=%0b", b, z, match_cnt, z2, match_cnt2, cnt_sat2);
    endtask

    task automatic idle();
        @(negedge clk);
        en = 1'b0;
        @(posedge clk);
        #1;
        $display("idle z=%0b cnt=%0d", z, match_cnt);
    endtask

    task automatic do_clr();
        @(negedge clk);
        clr = 1'b1; en = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        clr = 1'b0;
        $display("clr z=%0b cnt=%0d sat=%0b", z, match_cnt, cnt_sat);
    endtask

    task automatic test_reset();
        #3;
        vectors++;
        if ({z, match_cnt, cnt_sat} !== 10'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got z=%0b cnt=%0d sat=%0b, want 0 0 0", z, match_cnt, cnt_sat);
        end
        vectors++;
        if ({z2, match_cnt2, cnt_sat2} !== 4'd0) begin
            miscompares++;
            $display("FAIL reset_outputs2: got z=%0b cnt=%0d sat=%0b, want 0 0 0", z2, match_cnt2, cnt_sat2);
        end
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_overlap();
        logic s [7] = '{1, 1, 0, 1, 1, 0, 1};
        logic e [7] = '{0, 0, 0, 1, 0, 0, 1};
        do_clr();
        pat = 8'b00001101; len = 4'd4; overlap = 1'b1;
        for (int i = 0; i < 7; i++) begin
            send(s[i]);
            vectors++;
            if (z !== e[i]) begin
                miscompares++;
                $display("FAIL overlap_z bit%0d: got %0b want %0b", i + 1, z, e[i]);
            end
        end
        vectors++;
        if (match_cnt !== 8'd2) begin
            miscompares++;
            $display("FAIL overlap_cnt: got %0d want 2", match_cnt);
        end
    endtask

    task automatic test_no_overlap();
        logic s [7] = '{1, 1, 0, 1, 1, 0, 1};
        logic e [7] = '{0, 0, 0, 1, 0, 0, 0};
        do_clr();
        pat = 8'b00001101; len = 4'd4; overlap = 1'b0;
        for (int i = 0; i < 7; i++) begin
            send(s[i]);
            vectors++;
            if (z !== e[i]) begin
                miscompares++;
                $display("FAIL nonoverlap_z bit%0d: got %0b want %0b", i + 1, z, e[i]);
            end
        end
        vectors++;
        if (match_cnt !== 8'd1) begin
            miscompares++;
            $display("FAIL nonoverlap_cnt: got %0d want 1", match_cnt);
        end
        overlap = 1'b1;
    endtask

    task automatic test_en_gap();
        do_clr();
        pat = 8'b00000011; len = 4'd2; overlap = 1'b1;
        send(1'b1);
        vectors++;
        if (z !== 1'b0) begin miscompares++; $display("FAIL gap_z bit1: got %0b want 0", z); end
        send(1'b1);
        vectors++;
        if (z !== 1'b1) begin miscompares++; $display("FAIL gap_z bit2: got %0b want 1", z); end
        for (int i = 0; i < 3; i++) begin
            idle();
            vectors++;
            if (z !== 1'b0) begin miscompares++; $display("FAIL gap_z idle%0d: got %0b want 0", i, z); end
        end
        send(1'b1);
        vectors++;
        if (z !== 1'b1) begin miscompares++; $display("FAIL gap_z bit3: got %0b want 1", z); end
        send(1'b0);
        vectors++;
        if (z !== 1'b0) begin miscompares++; $display("FAIL gap_z bit4: got %0b want 0", z); end
        send(1'b1);
        vectors++;
        if (z !== 1'b0) begin miscompares++; $display("FAIL gap_z bit5: got %0b want 0", z); end
        vectors++;
        if (match_cnt !== 8'd2) begin miscompares++; $display("FAIL gap_cnt: got %0d want 2", match_cnt); end
    endtask

    task automatic test_saturation();
        logic [1:0] ec [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        logic       es [5] = '{0, 0, 1, 1, 1};
        do_clr();
        pat = 8'h01; len = 4'd1; overlap = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send(1'b1);
            vectors++;
            if (match_cnt2 !== ec[i] || cnt_sat2 !== es[i] || z2 !== 1'b1) begin
                miscompares++;
                $display("FAIL sat_step%0d: got cnt=%0d sat=%0b z=%0b want cnt=%0d sat=%0b z=1",
                         i + 1, match_cnt2, cnt_sat2, z2, ec[i], es[i]);
            end
        end
        do_clr();
        vectors++;
        if (match_cnt2 !== 2'd0 || cnt_sat2 !== 1'b0 || z2 !== 1'b0) begin
            miscompares++;
            $display("FAIL sat_clr: got cnt=%0d sat=%0b z=%0b want 0 0 0", match_cnt2, cnt_sat2, z2);
        end
    endtask

    task automatic test_async_reset();
        logic s [7] = '{1, 1, 0, 1, 1, 1, 0};
        do_clr();
        pat = 8'b00001101; len = 4'd4; overlap = 1'b0;
        for (int i = 0; i < 7; i++) send(s[i]);
        vectors++;
        if (match_cnt !== 8'd1) begin miscompares++; $display("FAIL prereset_cnt: got %0d want 1", match_cnt); end
        #1;
        resetn = 1'b0;
        #1;
        vectors++;
        if (match_cnt !== 8'd0 || z !== 1'b0 || cnt_sat !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset: got cnt=%0d z=%0b sat=%0b want 0 0 0", match_cnt, z, cnt_sat);
        end
        @(negedge clk);
        resetn = 1'b1;
        send(1'b1);
        vectors++;
        if (z !== 1'b0) begin miscompares++; $display("FAIL postreset_z: got %0b want 0", z); end
        overlap = 1'b1;
    endtask

    task automatic test_len_bounds();
        logic s0 [7] = '{1, 1, 0, 1, 1, 0, 1};
        logic s9 [8] = '{1, 0, 1, 1, 0, 0, 1, 1};
        do_clr();
        pat = 8'b00001101; len = 4'd0; overlap = 1'b1;
        for (int i = 0; i < 7; i++) begin
            send(s0[i]);
            vectors++;
            if (z !== 1'b0) begin miscompares++; $display("FAIL len0_z bit%0d: got %0b want 0", i + 1, z); end
        end
        vectors++;
        if (match_cnt !== 8'd0) begin miscompares++; $display("FAIL len0_cnt: got %0d want 0", match_cnt); end
        do_clr();
        pat = 8'b10110011; len = 4'd9;
        for (int i = 0; i < 8; i++) begin
            send(s9[i]);
            vectors++;
            if (z !== (i == 7)) begin
                miscompares++;
                $display("FAIL len9_z bit%0d: got %0b want %0b", i + 1, z, (i == 7));
            end
        end
    endtask

    initial begin
        test_reset();
        test_overlap();
        test_no_overlap();
        test_en_gap();
        test_saturation();
        test_async_reset();
        test_len_bounds();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
